// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding select stage.
// Holds the forwarding-select encoding, the error-counter limit and a
// helper that decides whether a select value names an existing source.
package fwd_pkg;

  // Widest select the stage supports: NUM_SRC tops out at 16.
  localparam int FWD_SEL_MAX_W = 4;

  // Encoding of the three classic forwarding sources. Wider
  // configurations simply continue the numbering with extra paths.
  typedef enum logic [FWD_SEL_MAX_W-1:0] {
    FWD_SRC_RF    = 4'd0,
    FWD_SRC_EXMEM = 4'd1,
    FWD_SRC_MEMWB = 4'd2
  } fwd_src_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // True when sel names one of the num_src candidates.
  function automatic logic sel_is_legal(input int unsigned sel,
                                        input int unsigned num_src);
    return sel < num_src;
  endfunction

endpackage

// File: rtl/fwd_sel_comb.sv
// Purely combinational indexed select over NUM_SRC packed candidates.
// An out-of-range select returns zero data and raises sel_illegal; the
// registered stage above decides what to do with that.
module fwd_sel_comb
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         sel_data,
  output logic                      sel_illegal
);

  // Walk every real source and pick the one matching sel; an unmatched
  // select leaves the zero default, so no X and no out-of-range slice.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // through this block can leave a signal unassigned and infer a latch.
    sel_data    = '0;
    sel_illegal = !sel_is_legal(32'(sel), NUM_SRC);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_mux_reg.sv
// Registered N-source operand-forwarding select stage.
// Selects one of NUM_SRC candidates, registers it with stall/flush
// control and tracks illegal selects (sticky flag plus saturating count).
// Optional macro FWD_OPERAND_MUX_ERR_CNT_EN builds the 8-bit error
// counter; without it err_count is tied to zero and sel_err still works.
module fwd_operand_mux_reg
  import fwd_pkg::*;
#(
  parameter  int DATA_W  = 64,
  parameter  int NUM_SRC = 3,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      sel_err,
  output logic [7:0]                err_count
);

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("fwd_operand_mux_reg: NUM_SRC must be in 2..16");
  end

  logic [DATA_W-1:0] sel_data;
  logic              sel_illegal;

  fwd_sel_comb #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_sel (
    .src_data    (src_data),
    .sel         (sel),
    .sel_data    (sel_data),
    .sel_illegal (sel_illegal)
  );

  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_valid_d, out_valid_q;
  logic              sel_err_d, sel_err_q;
  logic              err_hit;

  // Next-state for the data path: flush beats stall beats capture.
  // An illegal select keeps the old data so nothing undefined is captured.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    err_hit     = 1'b0;
    if (flush) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      out_valid_d = in_valid;
      if (!sel_illegal) begin
        out_data_d = sel_data;
      end else if (in_valid) begin
        sel_err_d = 1'b1;
        err_hit   = 1'b1;
      end
    end
  end

  // Stage register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values and simulation matches the synthesized logic.
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

`ifdef FWD_OPERAND_MUX_ERR_CNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;

  // Count valid illegal captures, sticking at the maximum.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_hit && err_cnt_q != ERR_CNT_MAX) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_hit;
  assign unused_err_hit = err_hit;
  assign err_count      = '0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_fwd_operand_mux_reg.sv
// Self-checking bench for fwd_operand_mux_reg: a 3-source instance driven
// through capture/stall/flush/illegal-select/reset scenarios, plus a
// 4-source instance swept over every select. Expected outputs come from a
// small behavioural model and go through a scoreboard queue.
module tb_fwd_operand_mux_reg;

  localparam int DW = 64;

`ifdef FWD_OPERAND_MUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          err;
    logic [7:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3*DW-1:0]  src_data;
  logic [1:0]       sel;
  logic             in_valid, stall, flush;
  logic [DW-1:0]    out_data;
  logic             out_valid, sel_err;
  logic [7:0]       err_count;

  logic [4*DW-1:0]  src4;
  logic [1:0]       sel4;
  logic [DW-1:0]    out_data4;
  logic             out_valid4, sel_err4;
  logic [7:0]       err_count4;

  fwd_operand_mux_reg #(.DATA_W(DW), .NUM_SRC(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_data  (src_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  fwd_operand_mux_reg #(.DATA_W(DW), .NUM_SRC(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .src_data  (src4),
    .sel       (sel4),
    .in_valid  (1'b1),
    .stall     (1'b0),
    .flush     (1'b0),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .sel_err   (sel_err4),
    .err_count (err_count4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state for the 3-source instance.
  logic [DW-1:0] m_data;
  logic          m_valid, m_err;
  logic [7:0]    m_cnt;
  exp_t          sb[$];
  exp_t          sb4[$];
  bit            chk4 = 1'b0;

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic cycle(input logic rst, input logic fl, input logic st,
                       input logic iv, input logic [1:0] s);
    exp_t e, got;
    logic [DW-1:0] cand;
    reset = rst; flush = fl; stall = st; in_valid = iv; sel = s;
    if (rst) begin
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else if (fl) begin
      m_data = '0; m_valid = 1'b0;
    end else if (!st) begin
      m_valid = iv;
      if (s < 2'd3) begin
        cand   = src_data >> (int'(s) * DW);
        m_data = cand;
      end else if (iv) begin
        m_err = 1'b1;
        if (CNT_EN && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
    end
    e.data = m_data; e.valid = m_valid; e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    if (chk4) begin
      e.data  = rst ? '0 : (src4 >> (int'(sel4) * DW));
      e.valid = !rst;
      e.err   = 1'b0;
      e.cnt   = '0;
      sb4.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      check("out_data",  out_data,  got.data);
      check("out_valid", DW'(out_valid), DW'(got.valid));
      check("sel_err",   DW'(sel_err),   DW'(got.err));
      check("err_count", DW'(err_count), DW'(got.cnt));
    end
    if (chk4 && sb4.size() != 0) begin
      got = sb4.pop_front();
      check("n4_data",  out_data4,        got.data);
      check("n4_valid", DW'(out_valid4),  DW'(got.valid));
      check("n4_err",   DW'(sel_err4),    DW'(got.err));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; sel = '0;
    src_data = {64'h33, 64'h22, 64'h11};
    src4     = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    sel4     = '0;
    m_data = 'x; m_valid = 1'bx; m_err = 1'bx; m_cnt = 'x;

    // Reset state, with data/flush/stall inputs active to prove reset wins.
    cycle(1, 1, 1, 1, 2'd2);
    cycle(1, 0, 0, 1, 2'd1);

    // Basic capture and stall hold.
    cycle(0, 0, 0, 1, 2'd1);
    cycle(0, 0, 0, 1, 2'd2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 2'd0);
    cycle(0, 0, 0, 1, 2'd0);

    // Flush and stall together: flush wins.
    cycle(0, 1, 1, 1, 2'd1);

    // Illegal select with and without in_valid.
    cycle(0, 0, 0, 1, 2'd1);
    cycle(0, 0, 0, 1, 2'd3);
    cycle(0, 0, 0, 0, 2'd3);

    // Legal capture with in_valid low still updates data.
    cycle(0, 0, 0, 0, 2'd2);
    // Flush leaves error state alone.
    cycle(0, 1, 0, 1, 2'd3);
    // Stall with illegal select does no accounting.
    cycle(0, 0, 1, 1, 2'd3);

    // Random data through each legal source.
    for (int i = 0; i < 6; i++) begin
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle(0, 0, 0, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 2)));
    end

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 2'd3);

    // Reset during a stall with a valid operand held.
    src_data = {64'h33, 64'h22, 64'h11};
    cycle(0, 0, 0, 1, 2'd0);
    cycle(0, 0, 1, 1, 2'd2);
    cycle(1, 0, 1, 1, 2'd2);

    // 4-source sweep: every select is legal.
    chk4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      cycle(0, 0, 0, 1, 2'd0);
    end
    src4 = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
    for (int i = 3; i >= 0; i--) begin
      sel4 = 2'(i);
      cycle(0, 0, 0, 1, 2'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_operand_mux_reg.md
Name: fwd_operand_mux_reg

Overview:
Parametrised N-source operand-forwarding select stage for the pipelined RISC-V core.
- Picks one of NUM_SRC DATA_W-bit candidates (register file, EX/MEM, MEM/WB, extra forward paths) using a binary select.
- Registers the result into the next pipeline stage, with stall/flush control, valid tracking and illegal-select detection.
- Drop-in replacement for the fixed 3-input combinational forwarding selectors ahead of the ALU operand registers.

Parameters:
- DATA_W, 64, width of each candidate and of the output.
- NUM_SRC, 3, number of candidate sources; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), select width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- src_data  input  NUM_SRC*DATA_W  packed candidates; source k occupies bits [k*DATA_W +: DATA_W].
- sel  input  SEL_W  binary index of the chosen source.
- in_valid  input  1  current cycle carries a real operand.
- stall  input  1  hold the stage register.
- flush  input  1  kill the stage register contents.
- out_data  output  DATA_W  registered selected operand.
- out_valid  output  1  out_data holds a real operand.
- sel_err  output  1  sticky flag: an illegal sel was captured.
- err_count  output  8  saturating count of illegal-select captures.

Behaviour:
- Clock and reset: reset is synchronous, active-high, sampled on rising clk. All state updates on rising clk only.
- Reset values: out_data=0, out_valid=0, sel_err=0, err_count=0. Reset overrides flush, stall and all data inputs.
- Latency: one cycle from sel/src_data/in_valid to out_data/out_valid. No combinational input-to-output path.
- Priority per cycle: reset > flush > stall > capture.
- flush=1: out_valid<=0, out_data<=0. Error state is unchanged. Flush and stall together means flush wins.
- stall=1 (flush=0): out_data, out_valid, sel_err and err_count all hold. No illegal-select accounting.
- Capture (no reset/flush/stall), legal sel < NUM_SRC: out_data <= src_data[sel], out_valid <= in_valid.
  - Data is captured even when in_valid=0. Downstream must gate on out_valid.
- Capture with illegal sel >= NUM_SRC (possible only when NUM_SRC is not a power of 2):
  - out_data holds its previous value (deterministic hold; no latch inference anywhere).
  - out_valid <= in_valid.
  - If in_valid=1: sel_err <= 1 (sticky until reset) and err_count increments, saturating at 255.
  - Illegal sel with in_valid=0 is ignored for error purposes.
- No X propagation: every branch of the select assigns out_data explicitly.
- Reset asserted mid-stall or mid-flush sequence: the next edge yields the reset values regardless.

Optional Feature:
- Macro: FWD_OPERAND_MUX_ERR_CNT_EN.
- Defined: err_count is implemented as described above.
- Undefined: no counter register is built, err_count is tied to 0, and sel_err still operates.

Decomposition:
- Shared package fwd_pkg:
  - typedef of the forwarding-select encoding.
  - constants FWD_SRC_RF=0, FWD_SRC_EXMEM=1, FWD_SRC_MEMWB=2.
  - constant ERR_CNT_MAX=255.
- One natural sub-module, fwd_sel_comb: purely combinational indexed select plus illegal-select flag. The top keeps all registers and priority logic.

Test Plan:
- NUM_SRC=3, DATA_W=64: sources 0x11/0x22/0x33, sel=1, in_valid=1 -> next cycle out_data=0x22, out_valid=1.
- Capture 0x33 (sel=2), then stall=1 for 3 cycles with sel=0 -> out_data stays 0x33, out_valid=1; stall drops -> next cycle out_data=0x11.
- flush=1 and stall=1 in the same cycle -> next cycle out_valid=0, out_data=0; err state unchanged.
- out_data=0x22, then sel=3 with in_valid=1 -> out_data stays 0x22, sel_err=1, err_count=1. Next, sel=3 with in_valid=0 -> err_count stays 1.
- 300 consecutive illegal valid captures -> err_count saturates at 255. Macro undefined -> err_count=0 throughout.
- reset=1 during a stall with out_valid=1 -> next edge all outputs 0. NUM_SRC=4 sweep of sel 0..3 -> each source appears after 1 cycle, sel_err never set.
